// File: rtl/arb2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb2_pkg
// Description : Shared FSM encoding and default sizes for the 2:1 packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb2_pkg;

    localparam int c_data_w_dflt = 8;
    localparam int c_to_cyc_dflt = 16;

    localparam int c_st_w = 2;
    localparam logic [c_st_w-1:0] c_st_idle  = 2'd0;
    localparam logic [c_st_w-1:0] c_st_lock0 = 2'd1;
    localparam logic [c_st_w-1:0] c_st_lock1 = 2'd2;

endpackage
`default_nettype wire

// File: rtl/arb2_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : arb2_out_reg
// Description : One-entry output register slice; holds its beat until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    input  logic              i_out_ready,
    output logic              o_load_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_last;

    // A new beat may enter when the slot is empty or is draining this cycle.
    assign o_load_ready = !r_valid || i_out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule
`default_nettype wire

// File: rtl/arb2_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : arb2_rr_sel
// Description : Two-requester round-robin packet arbiter with registered output.
//               Define ARB2_TIMEOUT_EN to enable the idle-beat lock watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module arb2_rr_sel
    import arb2_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt,
    parameter int TO_CYC = c_to_cyc_dflt
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req0_last,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              req1_last,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              sel,
    output logic              busy,
    output logic              timeout
);

    logic [c_st_w-1:0] r_state;
    logic [c_st_w-1:0] w_state_nxt;
    logic              r_sel;
    logic              w_sel_nxt;
    logic              r_prio;
    logic              w_prio_nxt;
    logic              w_grant;
    logic              w_lock;
    logic              w_slot_ready;
    logic              w_cur_valid;
    logic              w_cur_last;
    logic [DATA_W-1:0] w_cur_data;
    logic              w_accept;
    logic              w_to_abort;

    assign w_lock      = (r_state != c_st_idle);
    assign w_cur_valid = r_sel ? req1_valid : req0_valid;
    assign w_cur_last  = r_sel ? req1_last  : req0_last;
    assign w_cur_data  = r_sel ? req1_data  : req0_data;
    assign w_accept    = w_lock && w_cur_valid && w_slot_ready;

    assign req0_ready = (r_state == c_st_lock0) && w_slot_ready;
    assign req1_ready = (r_state == c_st_lock1) && w_slot_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_prio_nxt  = r_prio;
        w_grant     = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (req0_valid || req1_valid) begin
                    // Contention goes to the pointer; otherwise to whoever asks.
                    w_grant     = (req0_valid && req1_valid) ? r_prio : req1_valid;
                    w_sel_nxt   = w_grant;
                    w_state_nxt = w_grant ? c_st_lock1 : c_st_lock0;
                end
            end
            c_st_lock0, c_st_lock1: begin
                if ((w_accept && w_cur_last) || w_to_abort) begin
                    w_state_nxt = c_st_idle;
                    w_prio_nxt  = !r_sel;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_sel   <= 1'b0;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

`ifdef ARB2_TIMEOUT_EN
    localparam int c_to_w = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_timeout;

    // The abort fires on the TO_CYC-th consecutive empty cycle of the lock.
    assign w_to_abort = w_lock && !w_cur_valid && (r_to_cnt == c_to_w'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_to_abort;
            if (!w_lock || w_cur_valid || w_to_abort) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_to;

    assign w_unused_to = ^TO_CYC;
    assign w_to_abort  = 1'b0;
    assign timeout     = 1'b0;
`endif

    arb2_out_reg #(
        .DATA_W (DATA_W)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_accept),
        .i_data       (w_cur_data),
        .i_last       (w_cur_last),
        .i_out_ready  (out_ready),
        .o_load_ready (w_slot_ready),
        .o_valid      (out_valid),
        .o_data       (out_data),
        .o_last       (out_last)
    );

    assign sel  = r_sel;
    assign busy = w_lock;

endmodule
`default_nettype wire

// File: tb/tb_arb2_rr_sel.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb2_rr_sel
// Description : Scoreboard bench for arb2_rr_sel; beats are checked in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb2_rr_sel;

    localparam int DATA_W = 8;
    localparam int TO_CYC = 4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req0_last, req0_ready;
    logic              req1_valid, req1_last, req1_ready;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              out_valid, out_last, out_ready;
    logic [DATA_W-1:0] out_data;
    logic              sel, busy, timeout;

    arb2_rr_sel #(
        .DATA_W (DATA_W),
        .TO_CYC (TO_CYC)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_last  (req0_last),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_last  (req1_last),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .sel        (sel),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beats are {last, data}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [8:0] q_exp[$];
    logic       ordy;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_to    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive at the falling edge, then sample the handshakes the next rising edge commits.
    task automatic cycle();
        logic [8:0] exp;
        @(negedge clk);
        out_ready  = ordy;
        req0_valid = (q0.size() != 0);
        {req0_last, req0_data} = req0_valid ? q0[0] : 9'h000;
        req1_valid = (q1.size() != 0);
        {req1_last, req1_data} = req1_valid ? q1[0] : 9'h000;
        #1;
        if (req0_valid && req0_ready) void'(q0.pop_front());
        if (req1_valid && req1_ready) void'(q1.pop_front());
        if (timeout) n_to++;
        if (out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
                check("unexp_beat", q_exp.size(), 1);
            end else begin
                exp = q_exp.pop_front();
                check("beat", {out_last, out_data}, exp);
            end
        end
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (q_exp.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        check("drain", q_exp.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        q_exp.delete();
        ordy = 1'b1;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        ordy  = 1'b1;
        out_ready  = 1'b1;
        req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_sel", sel, 0);
        check("rst_ovalid", out_valid, 0);
        check("rst_odata", out_data, 0);
        check("rst_olast", out_last, 0);
        check("rst_timeout", timeout, 0);
        check("rst_ready", {req1_ready, req0_ready}, 0);

        // Single-beat packet latency
        q0.push_back(9'h111);
        q_exp.push_back(9'h111);
        cycle();
        check("lat_c0_busy", busy, 0);
        check("lat_c0_ready", req0_ready, 0);
        cycle();
        check("lat_c1_busy", busy, 1);
        check("lat_c1_sel", sel, 0);
        check("lat_c1_ready", req0_ready, 1);
        cycle();
        check("lat_c2_ovalid", out_valid, 1);
        check("lat_c2_busy", busy, 0);
        check("lat_c2_exp", q_exp.size(), 0);

        // Round-robin with both requesters always valid
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            q0.push_back({1'b1, 8'(8'h00 + i)});
            q1.push_back({1'b1, 8'(8'h80 + i)});
            q_exp.push_back({1'b1, 8'(8'h00 + i)});
            q_exp.push_back({1'b1, 8'(8'h80 + i)});
        end
        drain(40);
        check("rr_q0_left", q0.size(), 0);
        check("rr_q1_left", q1.size(), 0);

        // Back-pressure on a 3-beat packet from req1
        do_reset();
        q1.push_back(9'h0A1);
        q1.push_back(9'h0A2);
        q1.push_back(9'h1A3);
        q_exp.push_back(9'h0A1);
        q_exp.push_back(9'h0A2);
        q_exp.push_back(9'h1A3);
        cycle();
        cycle();
        check("bp_first_ready", req1_ready, 1);
        ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("bp_hold_data", out_data, 8'hA1);
            check("bp_hold_valid", out_valid, 1);
            check("bp_stall_ready", req1_ready, 0);
        end
        ordy = 1'b1;
        drain(20);
        check("bp_q1_left", q1.size(), 0);

        // Reset in the middle of a packet
        do_reset();
        q1.push_back(9'h031);
        q1.push_back(9'h032);
        q1.push_back(9'h133);
        q_exp.push_back(9'h031);
        cycle();
        cycle();
        cycle();
        check("mid_beat2_ready", req1_ready, 1);
        check("mid_sel_before", sel, 1);
        rst_n = 1'b0;
        cycle();
        check("mid_busy", busy, 0);
        check("mid_ovalid", out_valid, 0);
        check("mid_sel", sel, 0);
        check("mid_odata", out_data, 0);
        q1.delete();
        rst_n = 1'b1;
        cycle();
        cycle();
        check("mid_no_partial", out_valid, 0);
        check("mid_exp", q_exp.size(), 0);

        // Lock with the owner going quiet
        do_reset();
        n_to = 0;
        q0.push_back(9'h041);
        q1.push_back(9'h151);
        q_exp.push_back(9'h041);
`ifdef ARB2_TIMEOUT_EN
        q_exp.push_back(9'h151);
        for (int i = 0; i < 6; i++) cycle();
        cycle();
        check("to_pulse", timeout, 1);
        check("to_idle", busy, 0);
        cycle();
        check("to_pulse_end", timeout, 0);
        check("to_grant_sel", sel, 1);
        check("to_grant_busy", busy, 1);
        drain(20);
        check("to_count", n_to, 1);
`else
        for (int i = 0; i < 12; i++) cycle();
        check("hold_busy", busy, 1);
        check("hold_sel", sel, 0);
        check("hold_timeout", n_to, 0);
        q0.push_back(9'h142);
        q_exp.push_back(9'h142);
        q_exp.push_back(9'h151);
        drain(20);
        check("hold_no_timeout", n_to, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
